// File: rtl/mandelbrot_host_link_if.sv
// rtl/mandelbrot_host_link_if.sv - command/result handshake bundle for the mandelbrot host link
//
// Purpose: groups the host-facing command and result valid/ready channels.
// Signals:
//   cmd_valid / cmd_ready / cmd_cfg / cmd_npix : command channel (master -> link)
//   res_valid / res_ready / res_ctr            : result channel (link -> master)
// Modports:
//   master : the host that issues commands and consumes results
//   slave  : the link itself
interface mandelbrot_host_link_if #(
  parameter int CFG_BITS = 24,
  parameter int CTRWIDTH = 7
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [CFG_BITS-1:0] cmd_cfg;
  logic [15:0]         cmd_npix;
  logic                res_valid;
  logic                res_ready;
  logic [CTRWIDTH-1:0] res_ctr;

  modport master (
    output cmd_valid, cmd_cfg, cmd_npix, res_ready,
    input  cmd_ready, res_valid, res_ctr
  );

  modport slave (
    input  cmd_valid, cmd_cfg, cmd_npix, res_ready,
    output cmd_ready, res_valid, res_ctr
  );
endinterface

// File: rtl/mandelbrot_host_link.sv
// rtl/mandelbrot_host_link.sv - host-side driver for the tiny-mandelbrot pin protocol
//
// Purpose: shifts a configuration word into the chip, pulses its reset, raises run,
// then for each finished pulse reads the iteration counter back as two nibbles and
// streams it out on the result channel.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   host         : command/result handshake bundle (slave side)
//   busy         : high in any state other than IDLE
//   ovf_err      : sticky, finished edge seen outside WAIT_FIN; cleared on command accept
//   tt_data      : chip ui_in[7], config bit while shifting, run otherwise
//   tt_shift     : chip ui_in[6], shift enable
//   tt_sel       : chip ui_in[1:0], counter nibble select
//   tt_rst_n     : chip reset
//   tt_ctr       : chip counter nibble (synchronised here)
//   tt_finished  : chip finished flag (synchronised here)
module mandelbrot_host_link #(
  parameter int CFG_BITS = 24,
  parameter int CTRWIDTH = 7,
  parameter int RST_CYC  = 4,
  parameter int SETTLE   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mandelbrot_host_link_if.slave host,
  output logic                  busy,
  output logic                  ovf_err,
  output logic                  tt_data,
  output logic                  tt_shift,
  output logic [1:0]            tt_sel,
  output logic                  tt_rst_n,
  input  logic [3:0]            tt_ctr,
  input  logic                  tt_finished
);
  localparam int CNT_W = $clog2(CFG_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CRST, S_RUN, S_WAIT_FIN, S_SEL_LO, S_SEL_HI, S_PUSH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [15:0]         npix_q, npix_d;
  logic [3:0]          lo_q, lo_d;
  logic                res_valid_q, res_valid_d;
  logic [CTRWIDTH-1:0] res_ctr_q, res_ctr_d;
  logic                ovf_q, ovf_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                tt_data_q, tt_data_d;
  logic                tt_shift_q, tt_shift_d;
  logic [1:0]          tt_sel_q, tt_sel_d;
  logic                tt_rst_n_q, tt_rst_n_d;

  logic [3:0]          ctr_s1_q, ctr_s2_q;
  logic                fin_s1_q, fin_s2_q, fin_prev_q, fin_edge_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    npix_d      = npix_q;
    lo_d        = lo_q;
    res_valid_d = res_valid_q;
    res_ctr_d   = res_ctr_q;
    ovf_d       = ovf_q;

    // Any finished edge the FSM is not waiting for is a lost pixel.
    if (fin_edge_q && (state_q != S_WAIT_FIN)) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (host.cmd_valid && cmd_ready_q) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          cfg_d   = host.cmd_cfg;
          npix_d  = (host.cmd_npix == 16'd0) ? 16'd1 : host.cmd_npix;
          ovf_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        // cfg_q holds the remaining bits left-aligned; its MSB is the bit on the pin.
        cfg_d = {cfg_q[CFG_BITS-2:0], 1'b0};
        if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
          state_d = S_CRST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CRST: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: state_d = S_WAIT_FIN;
      S_WAIT_FIN: begin
        if (fin_edge_q) begin
          state_d = S_SEL_LO;
          cnt_d   = '0;
        end
      end
      S_SEL_LO: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          lo_d    = ctr_s2_q;
          state_d = S_SEL_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEL_HI: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          res_ctr_d   = {ctr_s2_q[CTRWIDTH-5:0], lo_q};
          res_valid_d = 1'b1;
          state_d     = S_PUSH;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PUSH: begin
        if (host.res_ready) begin
          res_valid_d = 1'b0;
          npix_d      = npix_q - 16'd1;
          state_d     = (npix_q == 16'd1) ? S_IDLE : S_WAIT_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin outputs are registered from the next state so they line up with state_q.
    cmd_ready_d = (state_d == S_IDLE);
    tt_shift_d  = (state_d == S_SHIFT);
    tt_rst_n_d  = (state_d != S_CRST);
    tt_sel_d    = (state_d == S_SEL_HI) ? 2'd1 : 2'd0;
    if (state_d == S_SHIFT) begin
      tt_data_d = cfg_d[CFG_BITS-1];
    end else begin
      tt_data_d = (state_d == S_RUN) || (state_d == S_WAIT_FIN) || (state_d == S_SEL_LO) ||
                  (state_d == S_SEL_HI) || (state_d == S_PUSH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cfg_q       <= '0;
      npix_q      <= '0;
      lo_q        <= '0;
      res_valid_q <= 1'b0;
      res_ctr_q   <= '0;
      ovf_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      tt_data_q   <= 1'b0;
      tt_shift_q  <= 1'b0;
      tt_sel_q    <= 2'd0;
      tt_rst_n_q  <= 1'b0;
      ctr_s1_q    <= '0;
      ctr_s2_q    <= '0;
      fin_s1_q    <= 1'b0;
      fin_s2_q    <= 1'b0;
      fin_prev_q  <= 1'b0;
      fin_edge_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      npix_q      <= npix_d;
      lo_q        <= lo_d;
      res_valid_q <= res_valid_d;
      res_ctr_q   <= res_ctr_d;
      ovf_q       <= ovf_d;
      cmd_ready_q <= cmd_ready_d;
      tt_data_q   <= tt_data_d;
      tt_shift_q  <= tt_shift_d;
      tt_sel_q    <= tt_sel_d;
      tt_rst_n_q  <= tt_rst_n_d;
      ctr_s1_q    <= tt_ctr;
      ctr_s2_q    <= ctr_s1_q;
      fin_s1_q    <= tt_finished;
      fin_s2_q    <= fin_s1_q;
      fin_prev_q  <= fin_s2_q;
      // A level already high is not an edge; only a low-to-high transition counts.
      fin_edge_q  <= fin_s2_q & ~fin_prev_q;
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_ctr   = res_ctr_q;
  assign busy           = (state_q != S_IDLE);
  assign ovf_err        = ovf_q;
  assign tt_data        = tt_data_q;
  assign tt_shift       = tt_shift_q;
  assign tt_sel         = tt_sel_q;
  assign tt_rst_n       = tt_rst_n_q;
endmodule

// File: tb/tb_mandelbrot_host_link.sv
// tb/tb_mandelbrot_host_link.sv - directed self-checking bench for mandelbrot_host_link
module tb_mandelbrot_host_link;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, ovf_err, tt_data, tt_shift, tt_rst_n, tt_finished;
  logic [1:0] tt_sel;
  logic [3:0] tt_ctr;
  logic [6:0] chip_ctr;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mandelbrot_host_link_if #(.CFG_BITS(24), .CTRWIDTH(7)) hif ();

  mandelbrot_host_link #(.CFG_BITS(24), .CTRWIDTH(7), .RST_CYC(4), .SETTLE(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (hif),
    .busy        (busy),
    .ovf_err     (ovf_err),
    .tt_data     (tt_data),
    .tt_shift    (tt_shift),
    .tt_sel      (tt_sel),
    .tt_rst_n    (tt_rst_n),
    .tt_ctr      (tt_ctr),
    .tt_finished (tt_finished)
  );

  // Chip model: counter nibble muxed by ctr_select.
  assign tt_ctr = tt_sel[0] ? {1'b0, chip_ctr[6:4]} : chip_ctr[3:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [23:0] cfg, input logic [15:0] npix);
    int n = 0;
    hif.cmd_valid = 1'b1;
    hif.cmd_cfg   = cfg;
    hif.cmd_npix  = npix;
    while (!hif.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_accept", hif.cmd_ready, 1);
    tick();
    hif.cmd_valid = 1'b0;
  endtask

  task automatic shift_capture(output logic [23:0] bits, output int n);
    bits = '0;
    n = 0;
    while (tt_shift && n < 40) begin
      bits = {bits[22:0], tt_data};
      n++;
      tick();
    end
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (tt_rst_n && n < 60) begin tick(); n++; end
    while (!tt_rst_n && n < 60) begin tick(); n++; end
    chk(tag, tt_data, 1);
    tick();
  endtask

  task automatic do_pixel(input string tag, input logic [6:0] val, output logic [3:0] seen);
    int n = 0;
    chip_ctr = val;
    tt_finished = 1'b1;
    tick();
    tick();
    tt_finished = 1'b0;
    seen = '0;
    while (!hif.res_valid && n < 100) begin
      seen[tt_sel] = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_valid"}, hif.res_valid, 1);
    chk({tag, "_ctr"}, hif.res_ctr, val);
  endtask

  task automatic handshake();
    if (hif.res_ready) begin
      tick();
    end else begin
      hif.res_ready = 1'b1;
      tick();
      hif.res_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] bits;
    logic [3:0]  seen;
    logic        stable;
    int          n;
    int          m;

    rst_n         = 1'b0;
    tt_finished   = 1'b0;
    chip_ctr      = '0;
    hif.cmd_valid = 1'b0;
    hif.cmd_cfg   = '0;
    hif.cmd_npix  = '0;
    hif.res_ready = 1'b0;
    tick(); tick(); tick();
    chk("reset_outs", {hif.cmd_ready, hif.res_valid, hif.res_ctr, busy, ovf_err,
                       tt_data, tt_shift, tt_sel, tt_rst_n}, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_ready", {hif.cmd_ready, tt_rst_n, busy}, 3'b110);

    // 1: configuration shift, chip reset, run
    send_cmd(24'hA5F00F, 16'd1);
    shift_capture(bits, n);
    chk("t1_nshift", n, 24);
    chk("t1_bits", bits, 24'hA5F00F);
    m = 0;
    while (!tt_rst_n && m < 20) begin
      if (tt_data) m = m + 100;
      m++;
      tick();
    end
    chk("t1_rst_cyc", m, 4);
    chk("t1_run", tt_data, 1);
    tick();

    // 2: single pixel readback
    do_pixel("t2", 7'h5B, seen);
    chk("t2_sel_seen", seen, 4'b0011);
    handshake();
    chk("t2_done", {busy, tt_data, hif.cmd_ready}, 3'b001);

    // 3: three pixels with res_ready held high
    send_cmd(24'h000123, 16'd3);
    wait_run("t3_run");
    hif.res_ready = 1'b1;
    do_pixel("t3a", 7'h01, seen);
    handshake();
    chk("t3_busy", busy, 1);
    do_pixel("t3b", 7'h40, seen);
    handshake();
    do_pixel("t3c", 7'h7F, seen);
    handshake();
    hif.res_ready = 1'b0;
    chk("t3_ready", {hif.cmd_ready, busy}, 2'b10);

    // 4: result stall, overflow during stall
    send_cmd(24'h0F0F0F, 16'd1);
    wait_run("t4_run");
    do_pixel("t4", 7'h2A, seen);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin chip_ctr = 7'h11; tt_finished = 1'b1; end
      if (i == 12) tt_finished = 1'b0;
      if (hif.res_valid !== 1'b1 || hif.res_ctr !== 7'h2A) stable = 1'b0;
      tick();
    end
    chk("t4_stable", stable, 1);
    chk("t4_hold", hif.res_ctr, 7'h2A);
    chk("t4_ovf", ovf_err, 1);
    handshake();
    chk("t4_idle", busy, 0);
    chk("t4_ovf_sticky", ovf_err, 1);

    // 5: asynchronous reset in the middle of the shift
    send_cmd(24'h123456, 16'd1);
    chk("t5_ovf_clr", ovf_err, 0);
    repeat (10) tick();
    chk("t5_pre", tt_shift, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async", {hif.cmd_ready, hif.res_valid, hif.res_ctr, busy, ovf_err,
                     tt_data, tt_shift, tt_sel, tt_rst_n}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    send_cmd(24'hC3A50F, 16'd1);
    shift_capture(bits, n);
    chk("t5_nshift", n, 24);
    chk("t5_bits", bits, 24'hC3A50F);
    wait_run("t5_run");
    do_pixel("t5", 7'h66, seen);
    handshake();
    chk("t5_idle", busy, 0);

    // 6: npix=0 yields one result; held cmd_valid is ignored while busy
    send_cmd(24'h0000AA, 16'd0);
    hif.cmd_valid = 1'b1;
    hif.cmd_cfg   = 24'hFFFFFF;
    hif.cmd_npix  = 16'd5;
    chk("t6_blocked", hif.cmd_ready, 0);
    wait_run("t6_run");
    do_pixel("t6", 7'h33, seen);
    chk("t6_blocked2", hif.cmd_ready, 0);
    handshake();
    chk("t6_one", {busy, hif.cmd_ready, tt_data}, 3'b010);
    hif.cmd_valid = 1'b0;
    tick(); tick();
    chk("t6_idle", {busy, tt_shift}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
